quire_normalizer: RTL and testbench



---
 rtl/quire_normalizer_pkg.sv | 25 ++
 rtl/quire_normalizer_leading_one_detector.sv | 26 ++
 rtl/quire_normalizer.sv | 206 ++++++++++++++++++++
 tb/tb_quire_normalizer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/quire_normalizer_pkg.sv
// Shared quire geometry helpers: quire width, 2^0 bit position, fraction and
// scale widths. These are also used by the accumulator and posit encoder.
package quire_normalizer_pkg;

   // Total quire width: 2^(es+2)*(n-2) dynamic-range bits, a sign bit and the carry guard.
   function automatic int quire_size_f(input int posit_width, input int es, input int log_nb_accum);
      return ((32'sd1 <<< (es + 32'sd2)) * (posit_width - 32'sd2)) + 32'sd1 + log_nb_accum;
   endfunction

   // Index of the quire bit carrying weight 2^0.
   function automatic int bpp_f(input int posit_width, input int es);
      return ((32'sd1 <<< (es + 32'sd2)) * (posit_width - 32'sd2)) / 32'sd2;
   endfunction

   // Fraction bits available below the hidden one in the narrowest posit regime.
   function automatic int frac_w_f(input int posit_width, input int es);
      return posit_width - es - 32'sd3;
   endfunction

   // Signed scale width: enough for any bit position of the quire, plus a sign.
   function automatic int scale_w_f(input int quire_size);
      return $clog2(quire_size) + 32'sd1;
   endfunction

endpackage

// File: rtl/quire_normalizer_leading_one_detector.sv
// Combinational priority encoder: position of the most significant set bit.
module leading_one_detector #(
   parameter  int WIDTH = 40,
   localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] vec,
   output logic [POS_W-1:0] pos,
   output logic             valid
);

   // Scan upward so the highest set bit is the last one to win.
   always_comb begin
      pos   = '0;
      valid = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            pos   = POS_W'(i);
            valid = 1'b1;
         end else begin
            pos   = pos;
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/quire_normalizer.sv
// Quire to sign/scale/fraction converter with guard and sticky bits.
// Three register stages (abs value, leading-one, normalise) behind a one-entry
// skid latch; the whole pipe stalls when the output is held by downstream.
module quire_normalizer
   import quire_normalizer_pkg::*;
#(
   parameter  int POSIT_WIDTH  = 8,
   parameter  int POSIT_ES     = 0,
   parameter  int LOG_NB_ACCUM = 15,
   localparam int QUIRE_SIZE   = quire_size_f(POSIT_WIDTH, POSIT_ES, LOG_NB_ACCUM),
   localparam int BPP          = bpp_f(POSIT_WIDTH, POSIT_ES),
   localparam int FRAC_W       = frac_w_f(POSIT_WIDTH, POSIT_ES),
   localparam int SCALE_W      = scale_w_f(QUIRE_SIZE)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      rtr_o,
   input  logic                      rts_i,
   input  logic                      sow_i,
   input  logic                      eow_i,
   input  logic [QUIRE_SIZE-1:0]     data_i,
   input  logic                      NaR_i,
   input  logic                      zero_i,
   input  logic                      rtr_i,
   output logic                      rts_o,
   output logic                      sow_o,
   output logic                      eow_o,
   output logic                      sign_o,
   output logic signed [SCALE_W-1:0] scale_o,
   output logic [FRAC_W-1:0]         fraction_o,
   output logic                      guard_o,
   output logic                      sticky_o,
   output logic                      zero_o,
   output logic                      NaR_o
);

   localparam int POS_W = $clog2(QUIRE_SIZE);

   typedef struct packed {
      logic [QUIRE_SIZE-1:0] data;
      logic                  nar;
      logic                  zero;
      logic                  sow;
      logic                  eow;
   } beat_t;

   logic                  process_en_s;
   logic                  receive_en_s;

   logic                  skid_valid_r;
   beat_t                 skid_r;

   beat_t                 in_beat_s;
   logic                  in_valid_s;
   logic                  in_sign_s;
   logic [QUIRE_SIZE-1:0] in_mag_s;
   logic                  in_zero_s;

   logic                  s1_valid_r, s1_sign_r, s1_nar_r, s1_zero_r, s1_sow_r, s1_eow_r;
   logic [QUIRE_SIZE-1:0] s1_mag_r;

   logic [POS_W-1:0]      lod_pos_s;
   logic                  lod_valid_s;

   logic                  s2_valid_r, s2_sign_r, s2_nar_r, s2_zero_r, s2_sow_r, s2_eow_r;
   logic [QUIRE_SIZE-1:0] s2_mag_r;
   logic [POS_W-1:0]      s2_pos_r;

   logic [POS_W-1:0]      shift_s;
   logic [QUIRE_SIZE-1:0] norm_s;
   logic [SCALE_W-1:0]    scale_s;

   assign process_en_s = rtr_i | ~rts_o;
   assign receive_en_s = rts_i & rtr_o;

   // Ready is the previous cycle's advance decision, so it never loops back combinationally.
   always_ff @(posedge clk) begin
      if (rst) rtr_o <= 1'b0;
      else     rtr_o <= process_en_s;
   end

   // Skid latch catches the one beat accepted in the cycle the pipe first stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid_r <= 1'b0;
         skid_r       <= '0;
      end else if (process_en_s) begin
         skid_valid_r <= 1'b0;
      end else if (receive_en_s) begin
         skid_valid_r <= 1'b1;
         skid_r       <= '{data: data_i, nar: NaR_i, zero: zero_i, sow: sow_i, eow: eow_i};
      end
   end

   // Input mux (latched beat first) and two's-complement magnitude.
   always_comb begin
      in_beat_s  = '{data: data_i, nar: NaR_i, zero: zero_i, sow: sow_i, eow: eow_i};
      in_valid_s = receive_en_s;
      if (skid_valid_r) begin
         in_beat_s  = skid_r;
         in_valid_s = 1'b1;
      end else begin
         in_beat_s  = in_beat_s;
         in_valid_s = in_valid_s;
      end
      in_sign_s = in_beat_s.data[QUIRE_SIZE-1];
      // Most negative quire negates to 2^(QUIRE_SIZE-1), still exact as unsigned.
      in_mag_s  = in_sign_s ? (~in_beat_s.data + QUIRE_SIZE'(1'b1)) : in_beat_s.data;
      in_zero_s = in_beat_s.zero | ~|in_beat_s.data;
   end

   // Stage 1: sign, magnitude and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_sign_r  <= 1'b0;
         s1_mag_r   <= '0;
         s1_nar_r   <= 1'b0;
         s1_zero_r  <= 1'b0;
         s1_sow_r   <= 1'b0;
         s1_eow_r   <= 1'b0;
      end else if (process_en_s) begin
         s1_valid_r <= in_valid_s;
         s1_sign_r  <= in_sign_s;
         s1_mag_r   <= in_mag_s;
         s1_nar_r   <= in_beat_s.nar;
         s1_zero_r  <= in_zero_s;
         s1_sow_r   <= in_beat_s.sow;
         s1_eow_r   <= in_beat_s.eow;
      end
   end

   leading_one_detector #(.WIDTH(QUIRE_SIZE)) u_lod (
      .vec   (s1_mag_r),
      .pos   (lod_pos_s),
      .valid (lod_valid_s)
   );

   // Stage 2: register the leading-one position next to the magnitude.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_sign_r  <= 1'b0;
         s2_mag_r   <= '0;
         s2_pos_r   <= '0;
         s2_nar_r   <= 1'b0;
         s2_zero_r  <= 1'b0;
         s2_sow_r   <= 1'b0;
         s2_eow_r   <= 1'b0;
      end else if (process_en_s) begin
         s2_valid_r <= s1_valid_r;
         s2_sign_r  <= s1_sign_r;
         s2_mag_r   <= s1_mag_r;
         s2_pos_r   <= lod_pos_s;
         s2_nar_r   <= s1_nar_r;
         s2_zero_r  <= s1_zero_r | ~lod_valid_s;
         s2_sow_r   <= s1_sow_r;
         s2_eow_r   <= s1_eow_r;
      end
   end

   // Normalise so the hidden one lands on the MSB; shifted-in low bits are zero.
   always_comb begin
      shift_s = POS_W'(QUIRE_SIZE - 1) - s2_pos_r;
      norm_s  = s2_mag_r << shift_s;
      scale_s = SCALE_W'({1'b0, s2_pos_r}) - SCALE_W'(BPP);
   end

   // Stage 3: registered outputs with NaR taking priority over zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rts_o      <= 1'b0;
         sow_o      <= 1'b0;
         eow_o      <= 1'b0;
         sign_o     <= 1'b0;
         scale_o    <= '0;
         fraction_o <= '0;
         guard_o    <= 1'b0;
         sticky_o   <= 1'b0;
         zero_o     <= 1'b0;
         NaR_o      <= 1'b0;
      end else if (process_en_s) begin
         rts_o <= s2_valid_r;
         sow_o <= s2_sow_r;
         eow_o <= s2_eow_r;
         if (s2_nar_r || s2_zero_r) begin
            sign_o     <= 1'b0;
            scale_o    <= '0;
            fraction_o <= '0;
            guard_o    <= 1'b0;
            sticky_o   <= 1'b0;
            zero_o     <= ~s2_nar_r;
            NaR_o      <= s2_nar_r;
         end else begin
            sign_o     <= s2_sign_r;
            scale_o    <= scale_s;
            fraction_o <= norm_s[QUIRE_SIZE-2 -: FRAC_W];
            guard_o    <= norm_s[QUIRE_SIZE-2-FRAC_W];
            sticky_o   <= |norm_s[QUIRE_SIZE-3-FRAC_W:0];
            zero_o     <= 1'b0;
            NaR_o      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quire_normalizer.sv
// Self-checking bench for quire_normalizer at default parameters
// (POSIT_WIDTH=8, ES=0, LOG_NB_ACCUM=15: 40-bit quire, 2^0 at bit 12).
module tb_quire_normalizer;

   localparam int QS = 40;

   logic              clk;
   logic              rst;
   logic              rtr_o;
   logic              rts_i;
   logic              sow_i;
   logic              eow_i;
   logic [QS-1:0]     data_i;
   logic              NaR_i;
   logic              zero_i;
   logic              rtr_i;
   logic              rts_o;
   logic              sow_o;
   logic              eow_o;
   logic              sign_o;
   logic signed [6:0] scale_o;
   logic [4:0]        fraction_o;
   logic              guard_o;
   logic              sticky_o;
   logic              zero_o;
   logic              NaR_o;

   int vectors;
   int miscompares;
   int skid_hits;
   logic [18:0] exp_q[$];

   quire_normalizer dut (
      .clk        (clk),
      .rst        (rst),
      .rtr_o      (rtr_o),
      .rts_i      (rts_i),
      .sow_i      (sow_i),
      .eow_i      (eow_i),
      .data_i     (data_i),
      .NaR_i      (NaR_i),
      .zero_i     (zero_i),
      .rtr_i      (rtr_i),
      .rts_o      (rts_o),
      .sow_o      (sow_o),
      .eow_o      (eow_o),
      .sign_o     (sign_o),
      .scale_o    (scale_o),
      .fraction_o (fraction_o),
      .guard_o    (guard_o),
      .sticky_o   (sticky_o),
      .zero_o     (zero_o),
      .NaR_o      (NaR_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value-level conversion of the quire using plain integer arithmetic.
   // Packed as {sow, eow, sign, scale[6:0], fraction[4:0], guard, sticky, zero, NaR}.
   function automatic logic [18:0] model(input logic [QS-1:0] d, input logic nar,
                                         input logic zin, input logic sow, input logic eow);
      logic sg, g, st, z;
      logic [4:0] fr;
      logic [6:0] sc7;
      int sc, p, q;
      longint unsigned m, ext;
      sg = 1'b0; sc = 0; fr = 5'd0; g = 1'b0; st = 1'b0; z = 1'b0;
      if (!nar && (zin || d == 40'd0)) begin
         z = 1'b1;
      end else if (!nar) begin
         sg = d[QS-1];
         m  = 64'(d);
         if (sg) m = (64'd1 << QS) - m;
         p = 0;
         while ((m >> (p + 1)) != 64'd0) p++;
         sc  = p - 12;
         ext = m << 6;           // six extra zero bits so tiny values still have fraction/guard slots
         q   = p + 6;
         fr  = 5'((ext >> (q - 5)) & 64'd31);
         g   = ((ext >> (q - 6)) & 64'd1) != 64'd0;
         st  = (ext & ((64'd1 << (q - 6)) - 64'd1)) != 64'd0;
      end
      sc7 = sc[6:0];
      return {sow, eow, sg, sc7, fr, g, st, z, nar};
   endfunction

   function automatic logic [18:0] observed();
      return {sow_o, eow_o, sign_o, scale_o, fraction_o, guard_o, sticky_o, zero_o, NaR_o};
   endfunction

   function automatic logic [QS-1:0] rand_quire();
      logic [63:0] raw;
      logic [QS-1:0] d;
      int mode;
      raw  = {$urandom, $urandom};
      mode = int'($urandom_range(0, 19));
      d    = raw[QS-1:0] >> $urandom_range(0, QS - 1);
      if (raw[63]) d = -d;
      if (mode == 0)      d = 40'd0;
      else if (mode == 1) d = 40'h80_0000_0000;
      else if (mode == 2) d = 40'hFF_FFFF_FFFF;
      return d;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: score the output handshake, record the input handshake, advance.
   task automatic cycle();
      logic [18:0] e;
      if (rts_o && rtr_i) begin
         if (exp_q.size() == 0) begin
            check("spurious_beat", 64'(rts_o), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat", 64'(observed()), 64'(e));
         end
      end
      if (rts_i && rtr_o && !rst) begin
         exp_q.push_back(model(data_i, NaR_i, zero_i, sow_i, eow_i));
         if (rts_o && !rtr_i) skid_hits++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [QS-1:0] d, input logic nar, input logic zin,
                       input logic sow, input logic eow);
      logic acc;
      int n;
      data_i = d; NaR_i = nar; zero_i = zin; sow_i = sow; eow_i = eow; rts_i = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         acc = rtr_o;
         cycle();
         n++;
      end
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      int n;
      rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; rtr_i = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         cycle();
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   logic [QS-1:0] dir_data [8];
   logic          dir_nar  [8];
   logic          dir_zin  [8];
   logic [QS-1:0] bp_data  [10];
   localparam logic [15:0] BP_PATTERN = 16'b1100_1011_0010_1101;

   initial begin
      int lat, sent, cyc, skid_before;
      logic acc;
      vectors = 0; miscompares = 0; skid_hits = 0;
      rst = 1'b1; rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; data_i = '0;
      NaR_i = 1'b0; zero_i = 1'b0; rtr_i = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_rtr", 64'(rtr_o), 64'd0);
      check("reset_rts", 64'(rts_o), 64'd0);
      check("reset_fields", 64'(observed()), 64'd0);
      rst = 1'b0;
      cycle();
      check("rtr_after_reset", 64'(rtr_o), 64'd1);

      // Latency of a single beat.
      send(40'h00_0000_1000, 1'b0, 1'b0, 1'b1, 1'b1);
      rts_i = 1'b0;
      lat = 1;
      while (!rts_o && lat < 10) begin
         cycle();
         lat++;
      end
      check("latency", 64'(lat), 64'd3);
      drain();

      // Directed values, back to back.
      dir_data[0] = 40'h00_0000_1000; dir_nar[0] = 1'b0; dir_zin[0] = 1'b0;
      dir_data[1] = 40'h00_0000_1801; dir_nar[1] = 1'b0; dir_zin[1] = 1'b0;
      dir_data[2] = 40'hFF_FFFF_F000; dir_nar[2] = 1'b0; dir_zin[2] = 1'b0;
      dir_data[3] = 40'h80_0000_0000; dir_nar[3] = 1'b0; dir_zin[3] = 1'b0;
      dir_data[4] = 40'h00_0000_0001; dir_nar[4] = 1'b0; dir_zin[4] = 1'b0;
      dir_data[5] = 40'h00_0000_0000; dir_nar[5] = 1'b0; dir_zin[5] = 1'b0;
      dir_data[6] = 40'h00_0000_1000; dir_nar[6] = 1'b1; dir_zin[6] = 1'b0;
      dir_data[7] = 40'h00_0000_1801; dir_nar[7] = 1'b0; dir_zin[7] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(dir_data[i], dir_nar[i], dir_zin[i], i == 0, i == 7);
      end
      drain();

      // Random values at full throughput.
      for (int i = 0; i < 150; i++) begin
         send(rand_quire(), $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      // Backpressure: 10-beat window with a fixed stall pattern on rtr_i.
      for (int i = 0; i < 10; i++) bp_data[i] = rand_quire();
      skid_before = skid_hits;
      sent = 0;
      cyc  = 0;
      rts_i = 1'b1; NaR_i = 1'b0; zero_i = 1'b0;
      while (sent < 10 && cyc < 200) begin
         data_i = bp_data[sent];
         sow_i  = (sent == 0);
         eow_i  = (sent == 9);
         rtr_i  = BP_PATTERN[cyc % 16];
         acc    = rtr_o;
         cycle();
         if (acc) sent++;
         cyc++;
      end
      check("bp_sent", 64'(sent), 64'd10);
      drain();
      check("skid_used", 64'(skid_hits > skid_before), 64'd1);

      // Random handshakes on both sides.
      for (int i = 0; i < 400; i++) begin
         rts_i  = 1'($urandom_range(0, 1));
         rtr_i  = $urandom_range(0, 3) != 0;
         data_i = rand_quire();
         NaR_i  = $urandom_range(0, 31) == 0;
         zero_i = $urandom_range(0, 31) == 0;
         sow_i  = 1'($urandom_range(0, 1));
         eow_i  = 1'($urandom_range(0, 1));
         cycle();
      end
      drain();

      // Reset with three beats in flight.
      rtr_i = 1'b1;
      for (int i = 0; i < 3; i++) send(rand_quire(), 1'b0, 1'b0, i == 0, i == 2);
      rts_i = 1'b0;
      rst   = 1'b1;
      cycle();
      check("rst_rts", 64'(rts_o), 64'd0);
      check("rst_rtr", 64'(rtr_o), 64'd0);
      exp_q.delete();
      rst = 1'b0;
      cycle();
      check("rtr_return", 64'(rtr_o), 64'd1);
      for (int i = 0; i < 6; i++) begin
         check("no_stale", 64'(rts_o), 64'd0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
